pwm_fade_ctrl: RTL and testbench
================================

# pwm_fade_ctrl

Duty-cycle sequencer that sits directly upstream of the `pwm` block and drives its `i_duty_cycle`. It accepts a target duty cycle over a valid/ready handshake and ramps its duty output toward that target in programmable steps. Every change is applied only at a PWM period boundary, so the downstream `pwm` never sees a mid-period duty change. It also provides the period-start strobe for other LED-effect logic.

## Interface
- `CLK_FREQ`, default 100000000: clock frequency in Hz.
- `PWM_FREQ`, default 20000: PWM frequency in Hz. Must match the downstream `pwm`.
- `WL`, default `$clog2(CLK_FREQ/PWM_FREQ)`: duty-cycle width.
- `STEP_WL`, default 8: width of the step size.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-low.
- `i_target`  in  WL: requested duty cycle.
- `i_target_valid`  in  1: request valid.
- `o_target_ready`  out  1: block can accept a request.
- `i_step`  in  STEP_WL: duty increment per step. Sampled on accept.
- `i_hold`  in  8: extra PWM periods between steps. Sampled on accept.
- `o_duty_cycle`  out  WL: connects to `pwm.i_duty_cycle`.
- `o_period_start`  out  1: one-cycle strobe on the first cycle of each PWM period.
- `o_busy`  out  1: ramp in progress.
- `o_done`  out  1: one-cycle pulse when the target is reached.

## Operation
- `MAX = CLK_FREQ/PWM_FREQ`. The period counter `per_cnt` runs 0..MAX and wraps, giving MAX+1 cycles per period, identical to `pwm`.
- `tick` is high when `per_cnt == MAX`.
- `o_period_start` is high when `per_cnt == 0`. It is registered.
- FSM has two states, IDLE and RAMP.
  - `o_target_ready` = (state == IDLE) while `rst` is high.
  - `o_busy` = (state == RAMP).
- IDLE, on `valid & ready`:
  - Latch `tgt = min(i_target, MAX)`, `step = (i_step == 0) ? 1 : i_step`, `hold = i_hold`.
  - Clear `hold_cnt`.
  - If `tgt == o_duty_cycle`: stay in IDLE and pulse `o_done` next cycle.
  - Otherwise go to RAMP.
- RAMP, on each `tick`:
  - If `hold_cnt != hold`: `hold_cnt++`.
  - Otherwise: `hold_cnt = 0` and update the duty.
  - Duty update: `d = |tgt − duty|`. If `d <= step`, duty = tgt, go to IDLE, pulse `o_done`. Otherwise duty moves by ±`step` toward `tgt`.
- `i_target_valid` during RAMP is not accepted. The requester holds its request until ready.
- Arithmetic is done in `max(WL, STEP_WL) + 1` bits with zero-extension. The duty never overshoots the target and never leaves 0..MAX.
- Reset values:
  - `o_duty_cycle` = 0, `per_cnt` = 0, `hold_cnt` = 0, state = IDLE.
  - `o_period_start`, `o_done`, `o_busy`, `o_target_ready` are all 0.
- Reset asserted mid-ramp abandons the ramp. All reset values apply on the next edge, and the latched target is discarded.

## Timing
- Handshake: a transfer occurs on a rising edge with `valid & ready` both high. `o_target_ready` drops the cycle after the accept whenever the FSM enters RAMP.
- Duty update latency:
  - The first possible update is at the first `tick` after the accept cycle, plus `hold` further ticks.
  - Each update is registered on the `tick` edge, so the new `o_duty_cycle` is valid from the cycle where `per_cnt == 0`.
  - `o_period_start` is high in that same cycle.
- `o_done` and the return of `o_target_ready` both occur in the cycle after the tick edge that writes the final duty.
- If accept and `tick` coincide, that tick does not count. Ramping starts at the following tick.
- `rst` high releases the block. The first `o_period_start` follows one cycle later, since `per_cnt == 0` on that cycle.

## Structure
- Shared package `pwm_pkg`:
  - function `pwm_max_cnt(clk_freq, pwm_freq)`, also used by `pwm`;
  - typedef `fade_state_t` with values IDLE and RAMP.
- Sub-module `pwm_period_timer`, parameters CLK_FREQ/PWM_FREQ. It owns `per_cnt` and outputs `tick` and `o_period_start`, and is reusable by other effect blocks.

## Test plan
All scenarios use CLK_FREQ=1000, PWM_FREQ=100, so MAX=10, WL=4 and the period is 11 cycles.
- Reset held 5 cycles, then released → `o_duty_cycle` = 0 and `o_target_ready` = 1; `o_period_start` pulses every 11 cycles starting 1 cycle after release.
- Target 10, step 3, hold 0, from duty 0 → duty 3, 6, 9, 10 on four consecutive period starts; single `o_done` pulse; ready returns afterwards.
- From duty 10: target 2, step 4, hold 1 → duty 6 after 2 periods, duty 2 after 4 periods; no overshoot.
- Target 15, step 0 → clamped to 10 with step 1; duty increments by 1 every period; valid pulses during RAMP are never accepted.
- Target equal to current duty → `o_done` the next cycle; duty unchanged; FSM stays in IDLE.
- `rst` low mid-ramp at duty 6 → next cycle duty = 0, FSM in IDLE, `per_cnt` = 0, no `o_done` pulse.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM family of blocks.
//   pwm_max_cnt  : terminal value of the PWM period counter (CLK_FREQ/PWM_FREQ).
//                  A period lasts pwm_max_cnt()+1 clock cycles.
//   fade_state_t : state encoding of the duty-cycle fade sequencer.
// -----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RAMP = 1'b1
   } fade_state_t;

   function automatic int pwm_max_cnt(input int clk_freq, input int pwm_freq);
      return clk_freq / pwm_freq;
   endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// -----------------------------------------------------------------------------
// pwm_period_timer
// Free-running PWM period counter, shared by effect blocks that must stay
// aligned with the downstream pwm. The counter runs 0..MAX and wraps.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous reset, active-low
//   o_tick         out  high in the last cycle of a period (per_cnt == MAX)
//   o_period_start out  registered strobe, high in the cycle where per_cnt == 0
// -----------------------------------------------------------------------------
module pwm_period_timer
   import pwm_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int PWM_FREQ = 20000
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick,
   output logic o_period_start
);

   localparam int            MAX   = pwm_max_cnt(CLK_FREQ, PWM_FREQ);
   localparam int            CW    = $clog2(MAX + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] per_cnt_q, per_cnt_d;
   logic          run_q;
   logic          period_start_q;

   // The counter rests at 0 for the first cycle out of reset, so the first
   // period begins one cycle after release with a visible start strobe.
   always_comb begin
      per_cnt_d = per_cnt_q;
      if (run_q) begin
         per_cnt_d = (per_cnt_q == MAX_C) ? '0 : per_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         per_cnt_q      <= '0;
         run_q          <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         per_cnt_q      <= per_cnt_d;
         run_q          <= 1'b1;
         period_start_q <= (per_cnt_d == '0);
      end
   end

   assign o_tick         = run_q && (per_cnt_q == MAX_C);
   assign o_period_start = period_start_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_fade_ctrl
// Duty-cycle sequencer feeding pwm.i_duty_cycle. Accepts a target duty and
// ramps toward it in steps of i_step, one step every (i_hold+1) PWM periods.
// The duty only changes on the last cycle of a period, so the new value is
// first seen in the cycle where the period restarts.
//
// Handshake: a request transfers on a rising edge where i_target_valid and
// o_target_ready are both high. The requester holds i_target/i_step/i_hold
// and valid until the transfer; requests are not accepted while ramping.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   i_target        requested duty (clamped to MAX on accept)
//   i_target_valid  request valid
//   o_target_ready  block idle and out of reset
//   i_step          duty increment per step (0 treated as 1), sampled on accept
//   i_hold          extra PWM periods between steps, sampled on accept
//   o_duty_cycle    duty output to pwm
//   o_period_start  one-cycle strobe in the first cycle of each PWM period
//   o_busy          ramp in progress
//   o_done          one-cycle pulse when the target has been reached
//   o_dbg_state     current sequencer state
// -----------------------------------------------------------------------------
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int PWM_FREQ = 20000,
   parameter int WL       = $clog2(CLK_FREQ / PWM_FREQ),
   parameter int STEP_WL  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WL-1:0]      i_target,
   input  logic               i_target_valid,
   output logic               o_target_ready,
   input  logic [STEP_WL-1:0] i_step,
   input  logic [7:0]         i_hold,
   output logic [WL-1:0]      o_duty_cycle,
   output logic               o_period_start,
   output logic               o_busy,
   output logic               o_done,
   output fade_state_t        o_dbg_state
);

   localparam int            MAX   = pwm_max_cnt(CLK_FREQ, PWM_FREQ);
   // One spare bit so duty +/- step cannot wrap before it is compared.
   localparam int            AW    = ((WL > STEP_WL) ? WL : STEP_WL) + 1;
   localparam logic [AW-1:0] MAX_A = AW'(MAX);

   fade_state_t        state_q, state_d;
   logic [WL-1:0]      duty_q, duty_d;
   logic [WL-1:0]      tgt_q, tgt_d;
   logic [STEP_WL-1:0] step_q, step_d;
   logic [7:0]         hold_q, hold_d;
   logic [7:0]         hold_cnt_q, hold_cnt_d;
   logic               done_q, done_d;

   logic               tick;
   logic               accept;
   logic [AW-1:0]      tgt_in_a, tgt_clamp_a;
   logic [AW-1:0]      duty_a, tgt_a, step_a, diff_a;

   pwm_period_timer #(
      .CLK_FREQ (CLK_FREQ),
      .PWM_FREQ (PWM_FREQ)
   ) u_timer (
      .clk            (clk),
      .rst            (rst),
      .o_tick         (tick),
      .o_period_start (o_period_start)
   );

   assign o_target_ready = rst && (state_q == IDLE);
   assign accept         = i_target_valid && o_target_ready;

   always_comb begin
      tgt_in_a    = AW'(i_target);
      tgt_clamp_a = (tgt_in_a > MAX_A) ? MAX_A : tgt_in_a;
      duty_a      = AW'(duty_q);
      tgt_a       = AW'(tgt_q);
      step_a      = AW'(step_q);
      diff_a      = (tgt_a >= duty_a) ? (tgt_a - duty_a) : (duty_a - tgt_a);
   end

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_d      = WL'(tgt_clamp_a);
               step_d     = (i_step == '0) ? STEP_WL'(1) : i_step;
               hold_d     = i_hold;
               hold_cnt_d = '0;
               if (tgt_clamp_a == duty_a) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RAMP;
               end
            end
         end
         RAMP: begin
            if (tick) begin
               if (hold_cnt_q != hold_q) begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end else begin
                  hold_cnt_d = '0;
                  // Landing exactly on the target when within one step
                  // keeps the duty from overshooting or leaving 0..MAX.
                  if (diff_a <= step_a) begin
                     duty_d  = tgt_q;
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else if (tgt_a > duty_a) begin
                     duty_d = WL'(duty_a + step_a);
                  end else begin
                     duty_d = WL'(duty_a - step_a);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         duty_q     <= '0;
         tgt_q      <= '0;
         step_q     <= '0;
         hold_q     <= '0;
         hold_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         tgt_q      <= tgt_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
         done_q     <= done_d;
      end
   end

   assign o_duty_cycle = duty_q;
   assign o_busy       = (state_q == RAMP);
   assign o_done       = done_q;
   assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_fade_ctrl
// Directed bench for pwm_fade_ctrl at CLK_FREQ=1000, PWM_FREQ=100
// (MAX=10, WL=4, 11-cycle period). Ramp requests come from a vector table
// with hand-computed duty sequences; reset behaviour is covered by
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pwm_fade_ctrl;
   import pwm_pkg::*;

   localparam int WL = 4;

   logic          clk;
   logic          rst;
   logic [WL-1:0] i_target;
   logic          i_target_valid;
   logic          o_target_ready;
   logic [7:0]    i_step;
   logic [7:0]    i_hold;
   logic [WL-1:0] o_duty_cycle;
   logic          o_period_start;
   logic          o_busy;
   logic          o_done;
   fade_state_t   o_dbg_state;

   int checks = 0;
   int errors = 0;
   logic [WL-1:0] exp_duty;

   // seq[k] is the duty expected after the k-th step of the ramp.
   typedef struct packed {
      logic [3:0]      target;
      logic [7:0]      step;
      logic [7:0]      hold;
      logic [3:0]      n_upd;
      logic            poke;
      logic [7:0][3:0] seq;
   } vec_t;

   vec_t vecs[4];

   pwm_fade_ctrl #(
      .CLK_FREQ (1000),
      .PWM_FREQ (100),
      .WL       (WL),
      .STEP_WL  (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_target       (i_target),
      .i_target_valid (i_target_valid),
      .o_target_ready (o_target_ready),
      .i_step         (i_step),
      .i_hold         (i_hold),
      .o_duty_cycle   (o_duty_cycle),
      .o_period_start (o_period_start),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_dbg_state    (o_dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Advance to the next period-start cycle of an active ramp. Optionally
   // pokes valid with target 0 to show it is refused while ramping.
   task automatic wait_period(input bit poke, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (poke) begin
            i_target       = 4'd0;
            i_target_valid = 1'($urandom_range(0, 1));
         end
         next_cycle();
         if (o_period_start) begin
            ok = 1'b1;
            break;
         end
         check_bit("done_quiet", o_done, 1'b0);
         check_bit("busy_in_ramp", o_busy, 1'b1);
         if (poke) check_bit("ready_low_in_ramp", o_target_ready, 1'b0);
      end
      i_target_valid = 1'b0;
      check_bit("period_start_seen", ok, 1'b1);
   endtask

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (o_target_ready) begin
            ok = 1'b1;
            break;
         end
         next_cycle();
      end
      check_bit("ready_before_req", ok, 1'b1);
   endtask

   task automatic request(input logic [3:0] tgt, input logic [7:0] stp, input logic [7:0] hld);
      i_target       = tgt;
      i_step         = stp;
      i_hold         = hld;
      i_target_valid = 1'b1;
      next_cycle();
      i_target_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit ok;

      vecs[0] = '{target: 4'd10, step: 8'd3, hold: 8'd0, n_upd: 4'd4, poke: 1'b0,
                  seq: {4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd9, 4'd6, 4'd3}};
      vecs[1] = '{target: 4'd2, step: 8'd4, hold: 8'd1, n_upd: 4'd2, poke: 1'b0,
                  seq: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd6}};
      vecs[2] = '{target: 4'd15, step: 8'd0, hold: 8'd0, n_upd: 4'd8, poke: 1'b1,
                  seq: {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3}};
      vecs[3] = '{target: 4'd10, step: 8'd5, hold: 8'd0, n_upd: 4'd0, poke: 1'b0,
                  seq: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};

      rst            = 1'b0;
      i_target       = '0;
      i_target_valid = 1'b0;
      i_step         = '0;
      i_hold         = '0;
      exp_duty       = '0;

      // Reset held for 5 cycles: every output at its reset value.
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         check_val("rst_duty", o_duty_cycle, 4'd0);
         check_bit("rst_ready", o_target_ready, 1'b0);
         check_bit("rst_period_start", o_period_start, 1'b0);
         check_bit("rst_done", o_done, 1'b0);
         check_bit("rst_busy", o_busy, 1'b0);
      end

      rst = 1'b1;
      #1;
      check_bit("release_ready", o_target_ready, 1'b1);
      check_bit("release_period_start", o_period_start, 1'b0);
      check_val("release_duty", o_duty_cycle, 4'd0);
      // First strobe one cycle after release, then every 11 cycles.
      for (int c = 1; c <= 23; c++) begin
         next_cycle();
         check_bit("period_start_pattern", o_period_start, ((c - 1) % 11) == 0);
      end

      // Table-driven ramp requests; each starts from the previous end duty.
      for (int v = 0; v < 4; v++) begin
         wait_ready();
         request(vecs[v].target, vecs[v].step, vecs[v].hold);
         if (vecs[v].n_upd == 4'd0) begin
            check_bit("equal_done", o_done, 1'b1);
            check_bit("equal_busy", o_busy, 1'b0);
            check_bit("equal_ready", o_target_ready, 1'b1);
            check_bit("equal_state_idle", o_dbg_state == IDLE, 1'b1);
            check_val("equal_duty", o_duty_cycle, exp_duty);
            next_cycle();
            check_bit("equal_done_single", o_done, 1'b0);
            check_val("equal_duty_after", o_duty_cycle, exp_duty);
         end else begin
            check_bit("accept_busy", o_busy, 1'b1);
            check_bit("accept_ready_low", o_target_ready, 1'b0);
            check_bit("accept_done", o_done, 1'b0);
            check_bit("accept_state_ramp", o_dbg_state == RAMP, 1'b1);
            for (int k = 0; k < int'(vecs[v].n_upd); k++) begin
               for (int p = 0; p <= int'(vecs[v].hold); p++) begin
                  wait_period(vecs[v].poke, ok);
                  if (p < int'(vecs[v].hold)) begin
                     check_val("duty_held", o_duty_cycle, exp_duty);
                     check_bit("done_held", o_done, 1'b0);
                  end else begin
                     exp_duty = vecs[v].seq[k];
                     check_val("duty_step", o_duty_cycle, exp_duty);
                     if (k == int'(vecs[v].n_upd) - 1) begin
                        check_bit("final_done", o_done, 1'b1);
                        check_bit("final_ready", o_target_ready, 1'b1);
                        check_bit("final_busy", o_busy, 1'b0);
                     end else begin
                        check_bit("mid_done", o_done, 1'b0);
                        check_bit("mid_busy", o_busy, 1'b1);
                     end
                  end
               end
            end
            next_cycle();
            check_bit("done_single", o_done, 1'b0);
            check_val("duty_stable", o_duty_cycle, exp_duty);
         end
      end

      // Reset in the middle of a ramp 10 -> 0 (step 4), after reaching 6.
      wait_ready();
      request(4'd0, 8'd4, 8'd0);
      wait_period(1'b0, ok);
      check_val("midrst_duty6", o_duty_cycle, 4'd6);
      rst = 1'b0;
      next_cycle();
      check_val("midrst_duty", o_duty_cycle, 4'd0);
      check_bit("midrst_busy", o_busy, 1'b0);
      check_bit("midrst_state_idle", o_dbg_state == IDLE, 1'b1);
      check_bit("midrst_done", o_done, 1'b0);
      check_bit("midrst_period_start", o_period_start, 1'b0);
      check_bit("midrst_ready", o_target_ready, 1'b0);
      rst = 1'b1;
      #1;
      check_bit("midrst_release_ready", o_target_ready, 1'b1);
      // Counter restarted from 0, and the abandoned ramp must not resume.
      for (int c = 1; c <= 13; c++) begin
         next_cycle();
         check_bit("midrst_period_start_pattern", o_period_start, ((c - 1) % 11) == 0);
         check_bit("midrst_no_done", o_done, 1'b0);
         check_val("midrst_duty_zero", o_duty_cycle, 4'd0);
         check_bit("midrst_idle", o_busy, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
